// File: rtl/serial_adder_pkg.sv
// ---------------------------------------------------------------------------
// serial_adder_pkg
//
// Purpose : Definitions shared by the bit-serial add/subtract controller:
//           the FSM state encoding, the legal operand width range and a
//           helper that sizes the bit counter.
//
// Contents: state_t    IDLE / RUN / DONE encoding
//           WIDTH_MIN  smallest supported operand width
//           WIDTH_MAX  largest supported operand width
//           cnt_width  bit-counter width for a given operand width
// ---------------------------------------------------------------------------
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    // The counter only has to reach WIDTH-1, so $clog2(WIDTH) bits are
    // enough.  The guard keeps the width at least 1 for degenerate values.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage : serial_adder_pkg

// File: rtl/serial_adder_ctrl_if.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl_if
//
// Purpose : Request/result bundle between a requesting controller and the
//           bit-serial adder.  clk and rst are not part of the bundle.
//
// Signals : start  request pulse, sampled only while the adder is idle
//           sub    0 = a + b + cin, 1 = a - b
//           a, b   WIDTH-bit operands, captured when a request is accepted
//           cin    carry-in for add, captured when a request is accepted
//           busy   operation in progress (through the done cycle)
//           done   one-cycle completion pulse
//           sum    result, held until the next completion
//           cout   final carry (for subtract, 1 = no borrow)
//           ovf    signed overflow
//
// Modports: master - requesting controller
//           slave  - serial_adder_ctrl
// ---------------------------------------------------------------------------
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);

    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start,
        output sub,
        output a,
        output b,
        output cin,
        input  busy,
        input  done,
        input  sum,
        input  cout,
        input  ovf
    );

    modport slave (
        input  start,
        input  sub,
        input  a,
        input  b,
        input  cin,
        output busy,
        output done,
        output sum,
        output cout,
        output ovf
    );

endinterface : serial_adder_ctrl_if

// File: rtl/serial_adder_ctrl_fa_bit.sv
// ---------------------------------------------------------------------------
// fa_bit
//
// Purpose : Purely combinational 1-bit full adder built the way the team's
//           cell library does it: a 3-to-8 decoder on {a, b, ci} whose
//           one-hot minterm lines are OR-reduced into sum and carry.
//
// Ports   : a   input  addend bit
//           b   input  addend bit
//           ci  input  carry in
//           s   output sum bit   = minterms 1, 2, 4, 7
//           co  output carry out = minterms 3, 5, 6, 7
// ---------------------------------------------------------------------------
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    // Minterm index is {a, b, ci}; bit k of each mask selects minterm k.
    localparam logic [7:0] SUM_MINTERMS   = 8'b1001_0110;
    localparam logic [7:0] CARRY_MINTERMS = 8'b1110_1000;

    logic [2:0] sel;
    logic [7:0] minterm;

    assign sel = {a, b, ci};

    // 3-to-8 decoder: exactly one line high.
    always_comb begin
        minterm = 8'b0;
        for (int k = 0; k < 8; k++) begin
            minterm[k] = (sel == 3'(k));
        end
    end

    assign s  = |(minterm & SUM_MINTERMS);
    assign co = |(minterm & CARRY_MINTERMS);

endmodule : fa_bit

// File: rtl/serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl
//
// Purpose : Bit-serial add/subtract controller wrapped around a single
//           fa_bit cell.  A WIDTH-bit operation is processed one bit per
//           cycle, LSB first, with the carry held in a register between
//           cycles.  Latency is traded for area: one operation takes
//           WIDTH + 2 cycles from accept to the first cycle back in IDLE.
//
// Ports   : clk  input  single clock, rising edge
//           rst  input  asynchronous, active-high reset
//           bus  slave modport of serial_adder_ctrl_if
//                (start, sub, a, b, cin in; busy, done, sum, cout, ovf out)
//
// Timing  : accept on edge 0 (IDLE & start), RUN on edges 1..WIDTH,
//           results and done registered on edge WIDTH+1, so done is high
//           in the cycle after edge WIDTH+1.  That cycle is already IDLE
//           internally, so a start presented then is accepted on edge
//           WIDTH+2.
// ---------------------------------------------------------------------------
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    serial_adder_ctrl_if.slave bus
);

    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("serial_adder_ctrl: WIDTH out of supported range");
    end

    // FSM and datapath state
    state_t           st_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] ps_q;
    logic             carry_q;
    logic             msb_ci_q;

    // Registered outputs
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             busy_q;
    logic             done_q;

    // Cell outputs for the current bit
    logic             fa_s;
    logic             fa_co;

    // Operand B as loaded on accept: subtract is A + ~B + 1.
    logic [WIDTH-1:0] b_load_d;
    logic             carry_load_d;

    assign b_load_d     = bus.sub ? ~bus.b : bus.b;
    assign carry_load_d = bus.sub ? 1'b1   : bus.cin;

    fa_bit u_fa (
        .a  (a_sh_q[0]),
        .b  (b_sh_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q     <= ST_IDLE;
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            ps_q     <= '0;
            carry_q  <= 1'b0;
            msb_ci_q <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;

            case (st_q)
                ST_IDLE: begin
                    // busy drops here together with done unless a new
                    // request is accepted on this same edge.
                    busy_q <= bus.start;
                    if (bus.start) begin
                        a_sh_q  <= bus.a;
                        b_sh_q  <= b_load_d;
                        carry_q <= carry_load_d;
                        cnt_q   <= '0;
                        ps_q    <= '0;
                        st_q    <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    // Sum bits enter at the MSB and walk down, so after
                    // WIDTH shifts bit 0 has arrived at position 0.
                    ps_q    <= {fa_s, ps_q[WIDTH-1:1]};
                    carry_q <= fa_co;
                    a_sh_q  <= a_sh_q >> 1;
                    b_sh_q  <= b_sh_q >> 1;
                    if (cnt_q == LAST_BIT) begin
                        // carry_q here is the carry into the MSB.
                        msb_ci_q <= carry_q;
                        st_q     <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                ST_DONE: begin
                    sum_q  <= ps_q;
                    cout_q <= carry_q;
                    ovf_q  <= msb_ci_q ^ carry_q;
                    done_q <= 1'b1;
                    st_q   <= ST_IDLE;
                end

                default: begin
                    st_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;

endmodule : serial_adder_ctrl

// File: tb/tb_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_adder_ctrl
//
// Self-checking bench for serial_adder_ctrl with WIDTH = 8: directed table
// vectors, busy rejection, mid-run reset, back-to-back with start held high
// and random operations against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_serial_adder_ctrl;

    localparam int W   = 8;
    localparam int LAT = W + 1;   // edges from accept edge to done-high
    localparam int PER = W + 2;   // accept-to-accept period

    logic clk;
    logic rst;

    serial_adder_ctrl_if #(.WIDTH(W)) bus ();

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;

    // Count done pulses away from the active edge.
    always @(negedge clk) begin
        if (bus.done === 1'b1) done_cnt++;
    end

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        logic         exp_ovf;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic.  Returns {ovf, cout, sum}.
    function automatic logic [W+1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic cin, input logic sub);
        longint ua, ub, sa, sb, full, sres, modv;
        logic [W-1:0] s;
        logic co, ov;
        modv = longint'(1) << W;
        ua = longint'(a);
        ub = longint'(b);
        sa = a[W-1] ? ua - modv : ua;
        sb = b[W-1] ? ub - modv : ub;
        if (sub) begin
            full = ua + (modv - 1 - ub) + 1;
            sres = sa - sb;
        end else begin
            full = ua + ub + longint'(cin);
            sres = sa + sb + longint'(cin);
        end
        s  = W'(full % modv);
        co = ((full / modv) % 2) != 0;
        ov = (sres < -(modv / 2)) || (sres > (modv / 2) - 1);
        return {ov, co, s};
    endfunction

    // One complete operation: present request, wait for done, check latency
    // and the done/busy fall.  Operands are scrambled after the accept edge.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub,
                         output logic [W-1:0] s, output logic co, output logic ov);
        int lat;
        bit seen;
        bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub; bus.start = 1'b1;
        tick();                                    // accept edge
        bus.start = 1'b0;
        bus.a = W'($urandom); bus.b = W'($urandom);
        bus.cin = 1'($urandom); bus.sub = 1'($urandom);
        lat = 0;
        seen = 0;
        for (int i = 0; i < 4 * W && !seen; i++) begin
            tick();
            lat++;
            if (lat == 1) check("busy_in_run", bus.busy, 1);
            if (bus.done === 1'b1) seen = 1;
        end
        check("done_seen", seen, 1);
        check("latency", lat, LAT);
        check("busy_at_done", bus.busy, 1);
        s = bus.sum; co = bus.cout; ov = bus.ovf;
        tick();
        check("done_pulse_falls", bus.done, 0);
        check("busy_falls", bus.busy, 0);
    endtask

    logic [W-1:0] r_s;
    logic         r_co, r_ov;
    logic [W+1:0] exp;
    logic [W+1:0] last_res;
    int           d0;

    logic [W-1:0] oa[64];
    logic [W-1:0] ob[64];
    logic         oc[64];
    logic         osb[64];

    initial begin
        tbl[0] = '{8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[2] = '{8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
        tbl[3] = '{8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0};
        tbl[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        tbl[5] = '{8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0};
        tbl[6] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        tbl[7] = '{8'h05, 8'h05, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};  // cin ignored for sub

        bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_sum", bus.sum, 0);
        check("rst_cout", bus.cout, 0);
        check("rst_ovf", bus.ovf, 0);
        rst = 1'b0;
        tick();

        // Directed table
        for (int i = 0; i < 8; i++) begin
            do_op(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, r_s, r_co, r_ov);
            check($sformatf("tbl%0d_sum", i), r_s, tbl[i].exp_sum);
            check($sformatf("tbl%0d_cout", i), r_co, tbl[i].exp_cout);
            check($sformatf("tbl%0d_ovf", i), r_ov, tbl[i].exp_ovf);
        end

        // Busy rejection: start pulses during RUN and during the DONE state
        d0 = done_cnt;
        bus.a = 8'h01; bus.b = 8'h01; bus.cin = 1'b0; bus.sub = 1'b0; bus.start = 1'b1;
        tick();                                    // accept edge 0
        bus.start = 1'b0;
        tick(); tick(); tick();                    // edges 1..3
        bus.a = 8'hAA; bus.start = 1'b1;
        tick();                                    // edge 4: RUN, ignored
        bus.start = 1'b0;
        for (int i = 5; i < W; i++) tick();        // up to edge W-1
        tick();                                    // edge W: now in DONE state
        bus.a = 8'hAA; bus.start = 1'b1;
        tick();                                    // edge W+1: ignored, done rises
        bus.start = 1'b0;
        check("rej_done_now", bus.done, 1);
        check("rej_sum", bus.sum, 8'h02);
        for (int i = 0; i < 3 * PER; i++) tick();
        check("rej_one_done", done_cnt - d0, 1);
        check("rej_idle", bus.busy, 0);
        do_op(8'h05, 8'h06, 1'b0, 1'b0, r_s, r_co, r_ov);
        check("rej_next_sum", r_s, 8'h0B);

        // Reset in the middle of RUN
        d0 = done_cnt;
        bus.a = 8'h5A; bus.b = 8'h3C; bus.cin = 1'b0; bus.sub = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("mid_busy_before", bus.busy, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_sum", bus.sum, 0);
        check("mid_rst_cout", bus.cout, 0);
        check("mid_rst_ovf", bus.ovf, 0);
        check("mid_rst_done", bus.done, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 2 * PER; i++) tick();
        check("mid_no_done", done_cnt - d0, 0);
        do_op(8'h03, 8'h04, 1'b0, 1'b0, r_s, r_co, r_ov);
        check("mid_next_sum", r_s, 8'h07);
        last_res = {r_ov, r_co, r_s};

        // Back-to-back with start held high, operands changing every cycle
        for (int c = 0; c < 4 * PER; c++) begin
            oa[c] = W'($urandom); ob[c] = W'($urandom);
            oc[c] = 1'($urandom); osb[c] = 1'($urandom);
            bus.a = oa[c]; bus.b = ob[c]; bus.cin = oc[c]; bus.sub = osb[c];
            bus.start = 1'b1;
            tick();                                // edge c
            if ((c % PER) == LAT) begin
                exp = ref_op(oa[c - LAT], ob[c - LAT], oc[c - LAT], osb[c - LAT]);
                check($sformatf("b2b_done_c%0d", c), bus.done, 1);
                check($sformatf("b2b_res_c%0d", c), {bus.ovf, bus.cout, bus.sum}, exp);
                last_res = exp;
            end else begin
                check($sformatf("b2b_nodone_c%0d", c), bus.done, 0);
                check($sformatf("b2b_hold_c%0d", c), {bus.ovf, bus.cout, bus.sum}, last_res);
                check($sformatf("b2b_busy_c%0d", c), bus.busy, 1);
            end
        end
        bus.start = 1'b0;
        // The last period's accept (edge 3*PER... start held through 4*PER-1)
        // began at edge 4*PER - PER; let it finish.
        for (int i = 0; i < PER + 2; i++) tick();
        check("b2b_drain_idle", bus.busy, 0);

        // Random operations against the reference model
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra, rb;
            logic rc, rsb;
            ra = W'($urandom); rb = W'($urandom);
            rc = 1'($urandom); rsb = 1'($urandom);
            if (i < 4) begin
                ra = (i[0]) ? {W{1'b1}} : '0;
                rb = (i[1]) ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
            end
            do_op(ra, rb, rc, rsb, r_s, r_co, r_ov);
            exp = ref_op(ra, rb, rc, rsb);
            check($sformatf("rnd%0d", i), {r_ov, r_co, r_s}, exp);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_serial_adder_ctrl

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

- Bit-serial add/subtract controller around one 1-bit full-adder cell.
- Accepts two WIDTH-bit operands on a start pulse and feeds the cell one bit per cycle, LSB first, with a registered carry.
- Reports the WIDTH-bit result, carry-out and signed overflow with a one-cycle done pulse.
- Sits between a requesting controller and the team's decoder-based full-adder cell, trading latency for area.

## Interface
Parameters:
- WIDTH, 8: operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- sub  input  1  0 = A+B+cin, 1 = A−B (B inverted, initial carry forced to 1, cin ignored).
- a  input  WIDTH  operand A, captured on accepted start.
- b  input  WIDTH  operand B, captured on accepted start.
- cin  input  1  carry-in for add, captured on accepted start.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse in DONE.
- sum  output  WIDTH  result register.
- cout  output  1  final carry; for sub, 1 = no borrow.
- ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on start=1.
  - RUN → DONE after the last bit (bit index WIDTH−1).
  - DONE → IDLE unconditionally.
- On accept (IDLE & start):
  - Load shift register A with a.
  - Load shift register B with sub ? ~b : b.
  - Load the carry register with sub ? 1 : cin.
  - Clear the bit counter and the partial-sum shift register.
- RUN, each cycle:
  - The cell takes A[0], B[0] and the carry register.
  - The cell's sum bit shifts into the MSB of the partial-sum register, which shifts right.
  - The cell's carry is written to the carry register.
  - A and B shift right and the counter increments.
- On the last RUN cycle, the carry into the MSB (the current carry register) is captured for the ovf computation.
- DONE:
  - sum ← partial-sum register; cout ← carry register; ovf ← captured MSB carry-in XOR carry register.
  - done=1 for exactly this cycle.
- Results hold until the next completion. They are not cleared on a new start.
- start outside IDLE (RUN or DONE) is ignored and not queued.
- Arithmetic is modulo 2^WIDTH. The counter is $clog2(WIDTH) bits and never wraps past WIDTH−1.

## Timing
- Reset values: FSM=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0; internal registers 0.
- Reset mid-operation aborts immediately: outputs return to reset values and no done pulse is issued.
- Latency:
  - Start accepted at edge 0.
  - RUN occupies edges 1..WIDTH.
  - done is high, with sum/cout/ovf valid, in the cycle following edge WIDTH+1.
- Throughput: one operation per WIDTH+2 cycles. The earliest next accept is the first cycle back in IDLE.
- busy rises the cycle after accept and falls in the same cycle done falls.
- Operand inputs a, b, cin and sub may change freely after the accept edge.

## Structure
- Shared package serial_adder_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - WIDTH bounds.
- One sub-module, fa_bit: a purely combinational 1-bit full adder (a, b, ci → s, co) built from the team's 3-to-8 decoder cell with OR-reduction of minterms.
- Everything else (FSM, counter, shift registers, result registers) lives in serial_adder_ctrl.

## Test plan
1. Add, WIDTH=8: a=0x5A, b=0x3C, cin=0, sub=0 → sum=0x96, cout=0, ovf=1; done exactly 10 cycles after accept.
2. Add wrap: a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, ovf=0. With cin=1 → sum=0x01, cout=1.
3. Subtract: a=0x10, b=0x20, sub=1 → sum=0xF0, cout=0, ovf=0. a=0x80, b=0x01, sub=1 → sum=0x7F, cout=1, ovf=1.
4. Busy rejection: start a=0x01, b=0x01, then pulse start with a=0xAA during RUN and DONE → one done only, sum=0x02. A subsequent start in IDLE is accepted.
5. Reset mid-RUN: assert rst at bit 4 of a 0x5A+0x3C operation → all outputs 0 immediately, no done pulse. Next op 0x03+0x04 → sum=0x07.
6. Back-to-back with start held high → accepts every WIDTH+2 cycles. Results of op N hold unchanged until op N+1's done.
